mux_rr_arbiter: RTL and testbench

Round-robin scheduler that shares the 4:1 4-bit mux datapath between four requesters (a, b, c, d). It drives the mux `sel` and captures the mux output `y` into a registered valid/ready output stage. Each winner may hold the mux for up to `BURST_LEN` consecutive transfers. The block sits directly between the requesters, the mux select input and the downstream consumer.

---
 rtl/mux_arb_pkg.sv | 23 ++
 rtl/mux_rr_pick.sv | 32 +++
 rtl/mux_rr_arbiter.sv | 127 ++++++++++++
 tb/tb_mux_rr_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the round-robin mux arbiter.
//   NREQ        number of requesters sharing the mux
//   SEL_W       width of the mux select / requester index
//   arb_state_t arbiter FSM state encoding
//   req_idx_t   requester index type
//   idx_onehot  converts a requester index to a one-hot vector
package mux_arb_pkg;

    localparam int NREQ  = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    typedef logic [SEL_W-1:0] req_idx_t;

    function automatic logic [NREQ-1:0] idx_onehot(input req_idx_t i);
        return NREQ'(1) << i;
    endfunction

endpackage

// File: rtl/mux_rr_pick.sv
// Combinational round-robin picker.
//   req   [3:0]  request vector
//   ptr   [1:0]  highest-priority position
//   found        at least one request is set
//   idx   [1:0]  first set request at or after ptr, wrapping 3 -> 0
module mux_rr_pick
    import mux_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  req_idx_t        ptr,
    output logic            found,
    output req_idx_t        idx
);

    req_idx_t cand;

    // Scan from the farthest offset down to ptr itself so the nearest
    // set bit (in wrapped order) is the last one written and wins.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = ptr + req_idx_t'(i);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin scheduler sharing a 4:1 mux between four requesters. It drives
// the mux select and captures the mux output into a one-entry output register.
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   req  [3:0] requester k has valid data on mux input k
//   gnt  [3:0] one-hot ready back to requesters
//   sel  [1:0] mux select, always the current (or last) owner
//   y    [DW]  mux output, combinational from sel
//   out_valid / out_ready / out_data / out_src  downstream output stage
//   busy       arbiter FSM is in BUSY (exposes the state)
//
// Handshakes: a beat moves only on a rising edge where valid and ready are both
// high in the same cycle. Upstream, req[k] is the valid and gnt[k] the ready, so a
// transfer is gnt[k] & req[k]; downstream, out_valid/out_ready. Valid must not
// depend on ready; gnt depends on out_ready so a full output register can be
// drained and refilled on the same edge.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int BURST_LEN = 4,
    parameter int DW        = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output req_idx_t        sel,
    input  logic [DW-1:0]   y,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output req_idx_t        out_src,
    output logic            busy
);

    arb_state_t    state_q, state_d;
    req_idx_t      owner_q, owner_d;
    req_idx_t      rr_ptr, rr_ptr_d;
    logic [3:0]    burst_cnt, burst_cnt_d;
    logic          out_valid_d;
    logic [DW-1:0] out_data_d;
    req_idx_t      out_src_d;

    logic          pick_found;
    req_idx_t      pick_idx;
    logic          slot_free;
    logic          xfer;
    logic          last_beat;

    mux_rr_pick u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign busy      = (state_q == BUSY);
    assign sel       = owner_q;
    assign slot_free = !out_valid || out_ready;
    assign gnt       = (busy && slot_free) ? idx_onehot(owner_q) : '0;
    assign xfer      = |(gnt & req);
    assign last_beat = (burst_cnt == 4'(BURST_LEN - 1));

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr;
        burst_cnt_d = burst_cnt;
        out_valid_d = out_valid;
        out_data_d  = out_data;
        out_src_d   = out_src;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d     = BUSY;
                    owner_d     = pick_idx;
                    burst_cnt_d = 4'd0;
                end
            end
            BUSY: begin
                if (xfer) begin
                    burst_cnt_d = burst_cnt + 4'd1;
                end
                // Release on a full burst or when the owner withdraws its
                // request; the released owner drops to lowest priority.
                if ((xfer && last_beat) || (!req[owner_q] && !xfer)) begin
                    state_d     = IDLE;
                    rr_ptr_d    = owner_q + req_idx_t'(1);
                    burst_cnt_d = 4'd0;
                end
            end
            default: state_d = IDLE;
        endcase

        // A transfer overwrites the register, which also covers a
        // simultaneous pop; a lone pop just empties it.
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = y;
            out_src_d   = owner_q;
        end else if (out_valid && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            rr_ptr    <= '0;
            burst_cnt <= 4'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_ptr    <= rr_ptr_d;
            burst_cnt <= burst_cnt_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            out_src   <= out_src_d;
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;
  import mux_arb_pkg::*;

  localparam int BL = 4;
  localparam int DW = 4;
  localparam int W  = DW + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]    req = 4'b0000;
  logic          out_ready = 1'b1;
  logic [3:0]    gnt;
  logic [1:0]    sel;
  logic [DW-1:0] y;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    out_src;
  logic          busy;

  logic [DW-1:0] src_data [4];
  assign y = src_data[sel];

  mux_rr_arbiter #(.BURST_LEN(BL), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .sel       (sel),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .busy      (busy)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Owner holds the mux for up to BL beats; the output stage is a queue of depth one.
  int            m_busy  = 0;
  int            m_owner = 0;
  int            m_ptr   = 0;
  int            m_beats = 0;
  logic [W-1:0]  exp_q[$];
  logic [DW-1:0] m_data = '0;
  logic [1:0]    m_src  = '0;

  task automatic model_step();
    bit slot;
    bit do_xfer;
    if (rst) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_beats = 0;
      exp_q.delete();
      m_data = '0; m_src = '0;
    end else begin
      slot    = (exp_q.size() == 0) || out_ready;
      do_xfer = (m_busy != 0) && slot && req[m_owner];
      if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
      if (do_xfer) begin
        m_data = src_data[m_owner];
        m_src  = 2'(m_owner);
        exp_q.push_back({m_src, m_data});
      end
      if (m_busy != 0) begin
        if (do_xfer) m_beats++;
        if ((do_xfer && m_beats == BL) || !req[m_owner]) begin
          m_busy  = 0;
          m_ptr   = (m_owner + 1) % 4;
          m_beats = 0;
        end
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (req[(m_ptr + i) % 4]) begin
            m_owner = (m_ptr + i) % 4;
            m_busy  = 1;
            m_beats = 0;
            break;
          end
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  // ---------------- scoreboard compare ----------------
  initial forever begin
    logic [3:0] eg;
    @(negedge clk);
    if (!rst) begin
      eg = ((m_busy != 0) && (exp_q.size() == 0 || out_ready)) ? (4'b0001 << m_owner) : 4'b0000;
      check("m_gnt",       32'(gnt),       32'(eg));
      check("m_sel",       32'(sel),       32'(m_owner));
      check("m_busy",      32'(busy),      32'(m_busy));
      check("m_out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      check("m_out_data",  32'(out_data),  32'(m_data));
      check("m_out_src",   32'(out_src),   32'(m_src));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [3:0] r, input logic rd);
    for (int k = 0; k < 4; k++)
      if (r[k] && !req[k]) src_data[k] = 4'($urandom_range(0, 15));
    req       = r;
    out_ready = rd;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    drive(4'b0000, 1'b1);
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [1:0] got_src [$];
    logic [1:0] exp_src [$];
    logic [3:0] r;
    for (int k = 0; k < 4; k++) src_data[k] = '0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_out_src", 32'(out_src), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);

    // Single requester c with data A
    #1 rst = 1'b0;
    drive(4'b0100, 1'b1);
    src_data[2] = 4'hA;
    @(negedge clk);
    check("single_sel", 32'(sel), 32'h2);
    check("single_busy", 32'(busy), 32'h1);
    check("single_gnt", 32'(gnt), 32'h4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("single_valid", 32'(out_valid), 32'h1);
      check("single_data", 32'(out_data), 32'hA);
      check("single_src", 32'(out_src), 32'h2);
      if (i < 3) check("single_busy_mid", 32'(busy), 32'h1);
    end
    check("single_release", 32'(busy), 32'h0);
    @(negedge clk);
    check("single_regrant_busy", 32'(busy), 32'h1);
    check("single_regrant_sel", 32'(sel), 32'h2);
    check("single_idle_pop", 32'(out_valid), 32'h0);

    // Backpressure after the first beat
    @(negedge clk);
    check("bp_first_beat", 32'(out_valid), 32'h1);
    #1 drive(4'b0100, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_gnt", 32'(gnt), 32'h0);
      check("bp_valid", 32'(out_valid), 32'h1);
      check("bp_data", 32'(out_data), 32'hA);
      check("bp_busy", 32'(busy), 32'h1);
    end
    #1 drive(4'b0100, 1'b1);
    @(negedge clk);
    check("bp_pop_xfer_valid", 32'(out_valid), 32'h1);
    check("bp_pop_xfer_gnt", 32'(gnt), 32'h4);
    @(negedge clk);
    check("bp_beat3_busy", 32'(busy), 32'h1);
    @(negedge clk);
    check("bp_beat4_release", 32'(busy), 32'h0);

    // Asynchronous reset mid-burst with data held
    @(negedge clk);
    @(negedge clk);
    check("mid_pre_valid", 32'(out_valid), 32'h1);
    #1 rst = 1'b1;
    #1;
    check("mid_gnt", 32'(gnt), 32'h0);
    check("mid_valid", 32'(out_valid), 32'h0);
    check("mid_data", 32'(out_data), 32'h0);
    check("mid_src", 32'(out_src), 32'h0);
    check("mid_busy", 32'(busy), 32'h0);
    @(negedge clk);
    #1 rst = 1'b0;
    drive(4'b1111, 1'b1);

    // All four requesting: bursts of BL beats in order 0,1,2,3,0
    for (int k = 0; k < 4; k++) for (int b = 0; b < BL; b++) exp_src.push_back(2'(k));
    exp_src.push_back(2'd0);
    for (int i = 0; i < 40 && got_src.size() < exp_src.size(); i++) begin
      @(negedge clk);
      if (i == 0) begin
        check("all_first_sel", 32'(sel), 32'h0);
        check("all_first_busy", 32'(busy), 32'h1);
      end
      if (out_valid) got_src.push_back(out_src);
    end
    check("all_beat_count", 32'(got_src.size()), 32'(exp_src.size()));
    for (int i = 0; i < exp_src.size() && i < got_src.size(); i++)
      check($sformatf("all_src[%0d]", i), 32'(got_src[i]), 32'(exp_src[i]));

    // Early drop by b, then d beats a; then d wraps the pointer to a
    do_reset();
    drive(4'b0010, 1'b1);
    @(negedge clk);
    check("drop_sel_b", 32'(sel), 32'h1);
    @(negedge clk);
    check("drop_beat_src", 32'(out_src), 32'h1);
    #1 drive(4'b1001, 1'b1);
    @(negedge clk);
    check("drop_release", 32'(busy), 32'h0);
    @(negedge clk);
    check("drop_d_wins", 32'(sel), 32'h3);
    check("drop_d_busy", 32'(busy), 32'h1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("wrap_d_src", 32'(out_src), 32'h3);
    end
    check("wrap_release", 32'(busy), 32'h0);
    @(negedge clk);
    check("wrap_a_sel", 32'(sel), 32'h0);
    check("wrap_a_busy", 32'(busy), 32'h1);

    // Random traffic checked by the model every cycle
    r = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      drive(r, $urandom_range(0, 3) != 0);
      if (i == 1500) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
